simon_core: RTL and testbench

Parametrised iterative SIMON block cipher core covering every SIMON 2N/MN variant from a single RTL source. A key is loaded once and expanded into an on-chip round-key store, after which any number of blocks can be encrypted or decrypted at one round per cycle. The core sits where fixed-variant SIMON tops sit today and keeps their load/done/read handshake, adding stored-key decryption and back-to-back block processing without re-expansion.

---
 rtl/simon_core_if.sv | 32 +++
 rtl/simon_core.sv | 146 ++++++++++++++
 tb/tb_simon_core.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_core_if.sv
// Handshake and data bundle between a SIMON core and its host.
// A host drives the master side and the core sits on the slave side.
interface simon_core_if #(
  parameter int N = 24,
  parameter int M = 4
);
  // newKey, newData and readData are sampled on a rising edge only while the core
  // shows loadKey, loadData or doneData for them. A request made outside that
  // window is dropped, not queued. In READY, newData wins over newKey.
  logic                  newKey;
  logic [M-1:0][N-1:0]   key;
  logic                  newData;
  logic                  enc_dec;
  logic [1:0][N-1:0]     inData;
  logic                  readData;
  logic                  loadKey;
  logic                  loadData;
  logic                  doneKey;
  logic                  doneData;
  logic [1:0][N-1:0]     outData;
  logic                  busy;

  modport master (
    output newKey, key, newData, enc_dec, inData, readData,
    input  loadKey, loadData, doneKey, doneData, outData, busy
  );

  modport slave (
    input  newKey, key, newData, enc_dec, inData, readData,
    output loadKey, loadData, doneKey, doneData, outData, busy
  );
endinterface

// File: rtl/simon_core.sv
// Iterative SIMON 2N/MN core: it expands the key once into a round-key store,
// then encrypts or decrypts blocks one round per cycle.
module simon_core #(
  parameter int N    = 24,
  parameter int M    = 4,
  parameter int T    = 36,
  parameter int ZSEL = 1,
  parameter int CB   = 7
) (
  input  logic        clk,
  input  logic        nR,
  simon_core_if.slave bus,
  output logic [2:0]  dbg_state
);
  localparam int AW = $clog2(T);

  localparam bit VALID =
    (N == 16 && M == 4 && T == 32 && ZSEL == 0) || (N == 24 && M == 3 && T == 36 && ZSEL == 0) ||
    (N == 24 && M == 4 && T == 36 && ZSEL == 1) || (N == 32 && M == 3 && T == 42 && ZSEL == 2) ||
    (N == 32 && M == 4 && T == 44 && ZSEL == 3) || (N == 48 && M == 2 && T == 52 && ZSEL == 2) ||
    (N == 48 && M == 3 && T == 54 && ZSEL == 3) || (N == 64 && M == 2 && T == 68 && ZSEL == 2) ||
    (N == 64 && M == 3 && T == 69 && ZSEL == 3) || (N == 64 && M == 4 && T == 72 && ZSEL == 4);

  if (!VALID || CB < $clog2(T + 1)) begin : g_bad_params
    $error("simon_core: unsupported N/M/T/ZSEL/CB combination");
  end

  // Bit j of each constant is element j of the z sequence.
  localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
  localparam logic [61:0] Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
  localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
  localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
  localparam logic [61:0] Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;
  localparam logic [61:0] ZC = (ZSEL == 0) ? Z0 : (ZSEL == 1) ? Z1 : (ZSEL == 2) ? Z2 :
                               (ZSEL == 3) ? Z3 : Z4;

  typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [CB-1:0]   cnt;
  logic [N-1:0]    rk [T];
  logic [N-1:0]    x, y, x_nx, y_nx;
  logic            enc;
  logic            key_valid;
  logic            take_key, take_data, last;

  function automatic logic [N-1:0] f_round(input logic [N-1:0] v);
    return ({v[N-2:0], v[N-1]} & {v[N-9:0], v[N-1:N-8]}) ^ {v[N-3:0], v[N-1:N-2]};
  endfunction

  assign take_data = (state == READY) && bus.newData;
  assign take_key  = bus.newKey && ((state == IDLE) || ((state == READY) && !bus.newData));
  assign last      = (cnt == CB'(T - 1));

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take_key) state_nx = KEXP;
      KEXP:    if (last) state_nx = READY;
      READY: begin
        if (take_data)     state_nx = RUN;
        else if (take_key) state_nx = KEXP;
      end
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.readData) state_nx = READY;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.loadKey  = (state == IDLE) || (state == READY);
    bus.loadData = (state == READY);
    bus.busy     = (state == KEXP) || (state == RUN);
    bus.doneData = (state == DONE);
    bus.doneKey  = key_valid;
    bus.outData  = {x, y};
    dbg_state    = 3'(state);
  end

  // Key expansion: cnt is the index of the round key being produced.
  logic [AW-1:0] i_cur, i_m1, i_m3, i_mm, rk_idx;
  logic [CB-1:0] z_raw;
  logic [5:0]    z_idx;
  logic [N-1:0]  tmp, k_new, rk_cur;

  always_comb begin
    i_cur  = cnt[AW-1:0];
    i_m1   = i_cur - AW'(1);
    i_m3   = i_cur - AW'(3);
    i_mm   = i_cur - AW'(M);
    z_raw  = cnt - CB'(M);
    z_idx  = (z_raw >= CB'(62)) ? 6'(z_raw - CB'(62)) : 6'(z_raw);
    tmp    = {rk[i_m1][2:0], rk[i_m1][N-1:3]};
    if (M == 4) tmp = tmp ^ rk[i_m3];
    tmp    = tmp ^ {tmp[0], tmp[N-1:1]};
    k_new  = ~rk[i_mm] ^ tmp ^ {{(N-1){1'b0}}, ZC[z_idx]} ^ N'(3);
    // Decryption walks the same store from the top down.
    rk_idx = enc ? i_cur : (AW'(T - 1) - i_cur);
    rk_cur = rk[rk_idx];
    if (enc) begin
      x_nx = y ^ f_round(x) ^ rk_cur;
      y_nx = x;
    end else begin
      x_nx = y;
      y_nx = x ^ f_round(y) ^ rk_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (take_key) begin
      for (int i = 0; i < M; i++) rk[i] <= bus.key[i];
    end else if (state == KEXP) begin
      rk[i_cur] <= k_new;
    end
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      enc       <= 1'b0;
      key_valid <= 1'b0;
    end else if (take_key) begin
      cnt       <= CB'(M);
      key_valid <= 1'b0;
    end else if (take_data) begin
      cnt <= '0;
      x   <= bus.inData[1];
      y   <= bus.inData[0];
      enc <= bus.enc_dec;
    end else if (state == KEXP) begin
      cnt <= last ? '0 : cnt + CB'(1);
      if (last) key_valid <= 1'b1;
    end else if (state == RUN) begin
      cnt <= last ? '0 : cnt + CB'(1);
      x   <= x_nx;
      y   <= y_nx;
    end
  end
endmodule

// File: tb/tb_simon_core.sv
// Bench for simon_core as SIMON 48/96: known-answer vectors, handshake corners,
// reset abort and encrypt/decrypt round trips against an in-bench cipher model.
module tb_simon_core;
  localparam int N = 24, M = 4, T = 36, ZSEL = 1, CB = 7;
  localparam logic [M*N-1:0] K1 = {24'h1a1918, 24'h121110, 24'h0a0908, 24'h020100};
  localparam logic [M*N-1:0] K2 = {24'h5a5a5a, 24'h0f0f0f, 24'h123456, 24'hfedcba};
  localparam logic [2*N-1:0] PT = {24'h726963, 24'h20646e};
  localparam logic [2*N-1:0] CT = {24'h6e06a5, 24'hacf156};
  // z1 in publication order: the leftmost bit is element 0.
  localparam logic [61:0] Z_STR = 62'b10001110111110010011000010110101000111011111001001100001011010;

  logic clk = 1'b0;
  logic nR  = 1'b0;
  logic [2:0] dbg_state;
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simon_core_if #(.N(N), .M(M)) bus ();

  simon_core #(.N(N), .M(M), .T(T), .ZSEL(ZSEL), .CB(CB)) dut (
    .clk(clk), .nR(nR), .bus(bus), .dbg_state(dbg_state)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Cipher model: plain key schedule plus Feistel loop.
  logic [N-1:0] m_rk [T];

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int j);
    return (v << j) | (v >> (N - j));
  endfunction

  function automatic logic [N-1:0] f_model(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  task automatic model_expand(input logic [M*N-1:0] k);
    logic [N-1:0] c, t;
    c = {N{1'b1}} - N'(3);
    for (int i = 0; i < M; i++) m_rk[i] = k[i*N +: N];
    for (int i = M; i < T; i++) begin
      t = rol(m_rk[i-1], N - 3) ^ m_rk[i-3];
      t = t ^ rol(t, N - 1);
      m_rk[i] = c ^ N'(Z_STR[61 - ((i - M) % 62)]) ^ m_rk[i-M] ^ t;
    end
  endtask

  function automatic logic [2*N-1:0] model_crypt(input logic [2*N-1:0] d, input bit e);
    logic [N-1:0] a, b, t;
    a = d[2*N-1:N];
    b = d[N-1:0];
    if (e) begin
      for (int r = 0; r < T; r++) begin
        t = a; a = b ^ f_model(a) ^ m_rk[r]; b = t;
      end
    end else begin
      for (int r = T - 1; r >= 0; r--) begin
        t = b; b = a ^ f_model(b) ^ m_rk[r]; a = t;
      end
    end
    return {a, b};
  endfunction

  // Scoreboard: expected results and their capture cycles.
  logic [2*N-1:0] exp_q[$];
  int             cap_q[$];
  logic [2*N-1:0] held;
  logic           done_q = 1'b0;
  int             t_cap;

  always @(negedge clk) begin
    if (nR) begin
      if (bus.doneData && !done_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.doneData), 64'd0);
        end else begin
          held  = exp_q.pop_front();
          t_cap = cap_q.pop_front();
          check("out_data", 64'(bus.outData), 64'(held));
          check("run_latency", 64'(cyc - t_cap), 64'(T));
        end
      end else if (bus.doneData) begin
        check("out_hold", 64'(bus.outData), 64'(held));
      end
    end
    done_q = bus.doneData;
  end

  task automatic load_key(input logic [M*N-1:0] k);
    bit ok;
    int e;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) if (bus.loadKey) ok = 1'b1; else @(negedge clk);
    check("load_key_wait", 64'(ok), 64'd1);
    bus.key = k;
    bus.newKey = 1'b1;
    @(negedge clk);
    bus.newKey = 1'b0;
    e = cyc;
    check("kexp_busy", 64'(bus.busy), 64'd1);
    check("kexp_doneKey_low", 64'(bus.doneKey), 64'd0);
    model_expand(k);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.doneKey) ok = 1'b1;
    end
    check("key_done_seen", 64'(ok), 64'd1);
    // Edge count from the accept edge, so doneKey is visible in cycle E+(T-M)+1.
    check("key_latency", 64'(cyc - e), 64'(T - M));
    check("key_load_data", 64'(bus.loadData), 64'd1);
    check("key_busy_low", 64'(bus.busy), 64'd0);
  endtask

  task automatic send_block(input logic [2*N-1:0] d, input bit e, output int cap);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) if (bus.loadData) ok = 1'b1; else @(negedge clk);
    check("load_data_wait", 64'(ok), 64'd1);
    bus.inData  = d;
    bus.enc_dec = e;
    bus.newData = 1'b1;
    @(negedge clk);
    bus.newData = 1'b0;
    cap = cyc;
    exp_q.push_back(model_crypt(d, e));
    cap_q.push_back(cap);
  endtask

  task automatic wait_done(output logic [2*N-1:0] o, input int delay, input bit poke);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) if (bus.doneData) ok = 1'b1; else @(negedge clk);
    check("done_wait", 64'(ok), 64'd1);
    if (poke) begin
      bus.key = K2; bus.newKey = 1'b1;
      bus.inData = ~PT; bus.newData = 1'b1;
      @(negedge clk);
      bus.newKey = 1'b0; bus.newData = 1'b0;
      check("done_ignores_req", 64'(bus.doneData), 64'd1);
      check("done_load_key_low", 64'(bus.loadKey), 64'd0);
      check("done_load_data_low", 64'(bus.loadData), 64'd0);
    end
    repeat (delay) @(negedge clk);
    o = bus.outData;
    bus.readData = 1'b1;
    @(negedge clk);
    bus.readData = 1'b0;
    check("read_release", 64'(bus.doneData), 64'd0);
    check("read_load_data", 64'(bus.loadData), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_loadKey"}, 64'(bus.loadKey), 64'd1);
    check({tag, "_loadData"}, 64'(bus.loadData), 64'd0);
    check({tag, "_doneKey"}, 64'(bus.doneKey), 64'd0);
    check({tag, "_doneData"}, 64'(bus.doneData), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_outData"}, 64'(bus.outData), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int cap;
    int caps[3];
    logic [2*N-1:0] o, ct, pt;
    logic [2*N-1:0] b2b[3];
    logic [95:0] r96;
    logic [63:0] r64;

    bus.newKey = 1'b0; bus.key = '0; bus.newData = 1'b0; bus.enc_dec = 1'b0;
    bus.inData = '0; bus.readData = 1'b0;
    b2b[0] = 48'h0123456789ab; b2b[1] = 48'hffffff000000; b2b[2] = 48'h000001800000;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    nR = 1'b1;
    @(negedge clk);

    // newData in IDLE must be dropped.
    bus.inData = PT; bus.enc_dec = 1'b1; bus.newData = 1'b1;
    @(negedge clk);
    bus.newData = 1'b0;
    @(negedge clk);
    check("idle_data_busy", 64'(bus.busy), 64'd0);
    check("idle_data_loadKey", 64'(bus.loadKey), 64'd1);

    load_key(K1);
    check("model_kat_enc", 64'(model_crypt(PT, 1'b1)), 64'(CT));
    check("model_kat_dec", 64'(model_crypt(CT, 1'b0)), 64'(PT));

    send_block(PT, 1'b1, cap);
    wait_done(o, 0, 1'b0);
    check("kat_enc", 64'(o), 64'(CT));
    send_block(CT, 1'b0, cap);
    wait_done(o, 0, 1'b0);
    check("kat_dec", 64'(o), 64'(PT));

    // Requests in DONE ignored; consumer waits 10 cycles before reading.
    send_block(PT, 1'b1, cap);
    wait_done(o, 10, 1'b1);
    check("delayed_read", 64'(o), 64'(CT));
    check("done_kept_key", 64'(bus.doneKey), 64'd1);

    // readData already high on the edge where doneData rises is not a read.
    send_block(CT, 1'b0, cap);
    while (cyc < cap + T - 1) @(negedge clk);
    check("pre_done_low", 64'(bus.doneData), 64'd0);
    bus.readData = 1'b1;
    @(negedge clk);
    check("same_edge_read", 64'(bus.doneData), 64'd1);
    check("same_edge_out", 64'(bus.outData), 64'(PT));
    @(negedge clk);
    bus.readData = 1'b0;
    check("read_consumed", 64'(bus.doneData), 64'd0);

    // Back-to-back blocks, one every T+2 cycles.
    for (int k = 0; k < 3; k++) begin
      send_block(b2b[k], 1'b1, caps[k]);
      wait_done(o, 0, 1'b0);
    end
    check("b2b_gap0", 64'(caps[1] - caps[0]), 64'(T + 2));
    check("b2b_gap1", 64'(caps[2] - caps[1]), 64'(T + 2));

    // newKey and newData together in READY: block runs under the old key.
    check("both_ready", 64'(bus.loadData), 64'd1);
    bus.key = K2; bus.newKey = 1'b1;
    bus.inData = PT; bus.enc_dec = 1'b1; bus.newData = 1'b1;
    @(negedge clk);
    bus.newKey = 1'b0; bus.newData = 1'b0;
    cap = cyc;
    exp_q.push_back(model_crypt(PT, 1'b1));
    cap_q.push_back(cap);
    check("both_busy", 64'(bus.busy), 64'd1);
    check("both_doneKey", 64'(bus.doneKey), 64'd1);
    wait_done(o, 0, 1'b0);
    check("both_old_key", 64'(o), 64'(CT));

    // Asynchronous reset in round 20 aborts immediately.
    send_block(PT, 1'b1, cap);
    while (cyc < cap + 20) @(negedge clk);
    check("mid_run_busy", 64'(bus.busy), 64'd1);
    #2 nR = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    cap_q.delete();
    repeat (2) @(negedge clk);
    nR = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_doneKey", 64'(bus.doneKey), 64'd0);
    check("post_reset_loadData", 64'(bus.loadData), 64'd0);
    check("post_reset_doneData", 64'(bus.doneData), 64'd0);
    load_key(K1);
    send_block(PT, 1'b1, cap);
    wait_done(o, 0, 1'b0);
    check("reload_kat", 64'(o), 64'(CT));

    // Round trips under fresh keys.
    for (int kk = 0; kk < 2; kk++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      load_key(r96);
      for (int j = 0; j < 4; j++) begin
        r64 = {$urandom(), $urandom()};
        pt = r64[2*N-1:0];
        send_block(pt, 1'b1, cap);
        wait_done(ct, $urandom_range(0, 3), 1'b0);
        send_block(ct, 1'b0, cap);
        wait_done(o, 0, 1'b0);
        check("round_trip", 64'(o), 64'(pt));
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
